// File: rtl/trace_arbiter.sv
// Merges level-held trace elements from two trackers into one ordered stream:
// edge-detect per source, 1-entry slot per source, round-robin into a show-ahead FIFO.
module trace_arbiter #(
  parameter int TRACE_WIDTH = 128,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           src0_ready_i,
  input  logic [TRACE_WIDTH-1:0]         src0_data_i,
  input  logic                           src1_ready_i,
  input  logic [TRACE_WIDTH-1:0]         src1_data_i,
  output logic                           trace_valid_o,
  output logic [TRACE_WIDTH-1:0]         trace_data_o,
  input  logic                           trace_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
  output logic [CNT_WIDTH-1:0]           drop_count_o,
  output logic                           overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]             src_ready;
  logic [TRACE_WIDTH-1:0] src_data [2];
  logic [1:0]             prev_ready_q;
  logic [TRACE_WIDTH-1:0] prev_data_q [2];
  logic [1:0]             slot_vld_q;
  logic [TRACE_WIDTH-1:0] slot_data_q [2];
  logic [1:0]             new_elem;
  logic [1:0]             drop;
  logic [1:0]             grant;
  logic                   prio_q, prio_d;

  logic [TRACE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [TRACE_WIDTH-1:0] head_q, head_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic [CNT_WIDTH:0]     drop_sum;
  logic                   ovf_q;
  logic                   pop, push, full, can_grant;
  logic [TRACE_WIDTH-1:0] push_data;

  assign src_ready   = {src1_ready_i, src0_ready_i};
  assign src_data[0] = src0_data_i;
  assign src_data[1] = src1_data_i;

  assign pop       = (count_q != '0) && trace_ready_i;
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign can_grant = !full || pop;
  assign grant[0]  = can_grant && slot_vld_q[0] && (!slot_vld_q[1] || !prio_q);
  assign grant[1]  = can_grant && slot_vld_q[1] && (!slot_vld_q[0] ||  prio_q);
  assign push      = |grant;
  assign push_data = grant[0] ? slot_data_q[0] : slot_data_q[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign new_elem[gi] = src_ready[gi] &&
                            (!prev_ready_q[gi] || (src_data[gi] != prev_data_q[gi]));
      // A slot being granted this cycle is free to take the new element.
      assign drop[gi] = new_elem[gi] && slot_vld_q[gi] && !grant[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          prev_ready_q[gi] <= 1'b0;
          prev_data_q[gi]  <= '0;
          slot_vld_q[gi]   <= 1'b0;
          slot_data_q[gi]  <= '0;
        end else begin
          prev_ready_q[gi] <= src_ready[gi];
          prev_data_q[gi]  <= src_data[gi];
          if (new_elem[gi] && !drop[gi]) begin
            slot_vld_q[gi]  <= 1'b1;
            slot_data_q[gi] <= src_data[gi];
          end else if (grant[gi]) begin
            slot_vld_q[gi]  <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    prio_d   = (&slot_vld_q && push) ? ~prio_q : prio_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Head register tracks the next head; it holds its value once the FIFO drains.
    head_d = head_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
      else                                head_d = mem[rd_ptr_d];
    end
    drop_sum = {1'b0, drop_q} + (CNT_WIDTH+1)'(drop[0]) + (CNT_WIDTH+1)'(drop[1]);
    drop_d   = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      drop_q   <= drop_d;
      if (|drop) ovf_q <= 1'b1;
    end
  end

  assign trace_valid_o = (count_q != '0);
  assign trace_data_o  = head_q;
  assign fifo_count_o  = count_q;
  assign drop_count_o  = drop_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: latency, ordering, round-robin, full FIFO,
// drop counting/saturation and reset flush, with hand-computed expectations.
module tb_trace_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         s0_rdy, s1_rdy, t_rdy;
  logic [127:0] s0_dat, s1_dat;
  logic         t_valid, ovf;
  logic [127:0] t_data;
  logic [3:0]   f_count;
  logic [15:0]  d_count;

  logic         z0_rdy, z1_rdy, z_trdy;
  logic [7:0]   z0_dat, z1_dat;
  logic         z_valid, z_ovf;
  logic [7:0]   z_data;
  logic [3:0]   z_count;
  logic [1:0]   z_drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] rr_exp [6];

  always #5 clk = ~clk;

  trace_arbiter u_dut (
    .clk(clk), .rst(rst),
    .src0_ready_i(s0_rdy), .src0_data_i(s0_dat),
    .src1_ready_i(s1_rdy), .src1_data_i(s1_dat),
    .trace_valid_o(t_valid), .trace_data_o(t_data), .trace_ready_i(t_rdy),
    .fifo_count_o(f_count), .drop_count_o(d_count), .overflow_o(ovf)
  );

  trace_arbiter #(.TRACE_WIDTH(8), .FIFO_DEPTH(8), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst),
    .src0_ready_i(z0_rdy), .src0_data_i(z0_dat),
    .src1_ready_i(z1_rdy), .src1_data_i(z1_dat),
    .trace_valid_o(z_valid), .trace_data_o(z_data), .trace_ready_i(z_trdy),
    .fifo_count_o(z_count), .drop_count_o(z_drop), .overflow_o(z_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s0_rdy = 1'b0; s1_rdy = 1'b0; t_rdy = 1'b0;
    s0_dat = '0;   s1_dat = '0;
    z0_rdy = 1'b0; z1_rdy = 1'b0; z_trdy = 1'b1;
    z0_dat = '0;   z1_dat = '0;
    rr_exp[0] = 128'h10; rr_exp[1] = 128'h20; rr_exp[2] = 128'h11;
    rr_exp[3] = 128'h22; rr_exp[4] = 128'h13; rr_exp[5] = 128'h24;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_valid", t_valid, 0);
    chk("rst_data", t_data, 0);
    chk("rst_count", f_count, 0);
    chk("rst_drop", d_count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sat_drop", z_drop, 0);

    // Held element is emitted once, two edges after first sample
    t_rdy = 1'b1; s0_rdy = 1'b1; s0_dat = 128'hA1;
    tick();
    chk("hold_e0_valid", t_valid, 0);
    tick();
    chk("hold_e1_valid", t_valid, 1);
    chk("hold_e1_data", t_data, 128'hA1);
    chk("hold_e1_count", f_count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_later_valid", t_valid, 0);
    end
    chk("hold_data_kept", t_data, 128'hA1);
    chk("hold_drop", d_count, 0);
    s0_rdy = 1'b0;
    tick();

    // Data changing under a held ready flag
    s0_rdy = 1'b1; s0_dat = 128'hA1;
    tick();
    s0_dat = 128'hA2;
    tick();
    chk("chg_d1", t_data, 128'hA1);
    chk("chg_c1", f_count, 1);
    s0_dat = 128'hA3;
    tick();
    chk("chg_d2", t_data, 128'hA2);
    chk("chg_c2", f_count, 1);
    tick();
    chk("chg_d3", t_data, 128'hA3);
    chk("chg_c3", f_count, 1);
    tick();
    chk("chg_empty", f_count, 0);
    s0_rdy = 1'b0;
    do_reset();

    // Both sources new every cycle: round-robin plus one drop per cycle
    s0_rdy = 1'b1; s1_rdy = 1'b1; z0_rdy = 1'b1; z1_rdy = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      s0_dat = 128'h10 + 128'(i); s1_dat = 128'h20 + 128'(i);
      z0_dat = 8'h10 + 8'(i);     z1_dat = 8'h20 + 8'(i);
      tick();
      if (i == 0) begin
        chk("rr_e0_valid", t_valid, 0);
      end else begin
        chk("rr_data", t_data, rr_exp[i-1]);
        chk("rr_count", f_count, 1);
        chk("rr_drop", d_count, 128'(i));
        chk("sat_drop", z_drop, (i < 3) ? 128'(i) : 128'd3);
      end
    end
    s0_rdy = 1'b0; s1_rdy = 1'b0; z0_rdy = 1'b0; z1_rdy = 1'b0;
    do_reset();

    // Fill the FIFO with the sink stalled
    t_rdy = 1'b0; s0_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s0_dat = 128'h40 + 128'(k);
      tick();
      tick();
    end
    chk("full_count", f_count, 8);
    chk("full_head", t_data, 128'h40);
    chk("full_ovf0", ovf, 0);
    s0_dat = 128'h48;
    tick();
    tick();
    chk("full_slot_count", f_count, 8);
    chk("full_slot_drop", d_count, 0);
    s0_dat = 128'h49;
    tick();
    chk("full_drop1", d_count, 1);
    chk("full_ovf1", ovf, 1);
    s1_rdy = 1'b1; s1_dat = 128'h90;
    tick();
    chk("full_s1_load", d_count, 1);
    s0_dat = 128'h4A; s1_dat = 128'h91;
    tick();
    chk("full_dual_drop", d_count, 3);
    t_rdy = 1'b1; s0_dat = 128'h4B;
    tick();
    chk("pp_count1", f_count, 8);
    chk("pp_head1", t_data, 128'h41);
    chk("pp_drop", d_count, 3);
    tick();
    chk("pp_count2", f_count, 8);
    chk("pp_head2", t_data, 128'h42);
    tick();
    chk("pp_count3", f_count, 8);
    chk("pp_head3", t_data, 128'h43);
    tick();
    chk("pp_count4", f_count, 7);
    chk("pp_head4", t_data, 128'h44);
    s0_rdy = 1'b0; s1_rdy = 1'b0;
    t_rdy = 1'b0;
    do_reset();

    // Count 5 with both slots full, then reset mid-operation
    s0_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s0_dat = 128'h50 + 128'(k);
      tick();
      tick();
    end
    s0_dat = 128'h60; s1_rdy = 1'b1; s1_dat = 128'h70;
    tick();
    chk("pre_count3", f_count, 3);
    s1_dat = 128'h71;
    tick();
    chk("pre_count4", f_count, 4);
    chk("pre_ovf", ovf, 1);
    s0_dat = 128'h61; s1_dat = 128'h72;
    tick();
    chk("pre_count5", f_count, 5);
    chk("pre_drop", d_count, 1);
    rst = 1'b1; t_rdy = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", t_valid, 0);
    chk("mid_rst_count", f_count, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_drop", d_count, 0);
    tick();
    chk("post_e0_valid", t_valid, 0);
    tick();
    chk("post_d0", t_data, 128'h61);
    chk("post_v0", t_valid, 1);
    tick();
    chk("post_d1", t_data, 128'h72);
    chk("post_v1", t_valid, 1);
    tick();
    chk("post_once_valid", t_valid, 0);
    tick();
    chk("post_once_count", f_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
